// File: rtl/fanout_pkg.sv
// Shared types and defaults for the fanout broadcast transmitter.
package fanout_pkg;

  localparam int unsigned FANOUT_NUM_BRANCHES = 6;
  localparam int unsigned FANOUT_DATA_WIDTH   = 17;
  localparam int unsigned FIFO_DEPTH          = 2;
  localparam int unsigned STALL_CNT_WIDTH     = 32;

  typedef struct packed {
    logic [FANOUT_DATA_WIDTH-1:0]   data;
    logic [FANOUT_NUM_BRANCHES-1:0] mask;
  } fanout_entry_t;

endpackage

// File: rtl/fanout_fifo2.sv
// Two-entry register FIFO holding {data, mask} tokens; head is read combinationally.
module fanout_fifo2
  import fanout_pkg::*;
#(
  parameter type entry_t = fanout_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam logic [1:0] DEPTH_CNT = 2'(FIFO_DEPTH);

  entry_t     mem_q [FIFO_DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fanout_broadcast.sv
// Eager-fork transmitter: each queued token is offered to every masked branch until all accept.
// Optional head-blocked stall counter enabled by defining FANOUT_STALL_CNT_EN.
module fanout_broadcast
  import fanout_pkg::*;
#(
  parameter int unsigned NUM_BRANCHES = FANOUT_NUM_BRANCHES,
  parameter int unsigned DATA_WIDTH   = FANOUT_DATA_WIDTH
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_BRANCHES-1:0]          branch_en,
  input  logic [NUM_BRANCHES-1:0]          branch_sel,
  output logic [NUM_BRANCHES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_BRANCHES-1:0]          out_valid,
  input  logic [NUM_BRANCHES-1:0]          out_ready
`ifdef FANOUT_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [NUM_BRANCHES-1:0] mask;
  } entry_t;

  entry_t                  push_entry;
  entry_t                  head;
  logic                    fifo_full, fifo_empty;
  logic                    head_valid;
  logic                    push, retire;
  logic [NUM_BRANCHES-1:0] acc;
  logic [NUM_BRANCHES-1:0] sent_q, sent_d;

  // in_ready depends only on occupancy, so a full FIFO refuses input even when the head retires.
  assign in_ready = ~fifo_full & ~RESET;
  assign push     = in_valid & in_ready;

  assign push_entry.data = in_data;
  assign push_entry.mask = branch_en & branch_sel;

  fanout_fifo2 #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (retire),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head_valid = ~fifo_empty;
  assign out_data   = {NUM_BRANCHES{head.data}};
  assign out_valid  = {NUM_BRANCHES{head_valid}} & head.mask & ~sent_q;
  assign acc        = out_valid & out_ready;
  // A zero mask satisfies this immediately, dropping the token on its first head cycle.
  assign retire     = head_valid & ((head.mask & ~(sent_q | acc)) == '0);

  always_comb begin
    sent_d = sent_q | acc;
    if (retire) sent_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end

`ifdef FANOUT_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (head_valid && !retire && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fanout_broadcast.sv
// Directed-vector bench for fanout_broadcast with hand-computed expectations.
module tb_fanout_broadcast;

  localparam int unsigned NB = 6;
  localparam int unsigned DW = 17;

  logic                CLK;
  logic                RESET;
  logic [DW-1:0]       in_data;
  logic                in_valid;
  logic                in_ready;
  logic [NB-1:0]       branch_en;
  logic [NB-1:0]       branch_sel;
  logic [NB*DW-1:0]    out_data;
  logic [NB-1:0]       out_valid;
  logic [NB-1:0]       out_ready;
`ifdef FANOUT_STALL_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  int unsigned n_cmp;
  int unsigned n_err;

  fanout_broadcast #(
    .NUM_BRANCHES (NB),
    .DATA_WIDTH   (DW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .branch_en  (branch_en),
    .branch_sel (branch_sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef FANOUT_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 2ns after the edge and checks run 1ns later.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    RESET      = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    branch_en  = 6'h3F;
    branch_sel = 6'h3F;
    out_ready  = 6'h3F;

    // Reset state
    tick(); tick(); settle();
    check_eq("rst_in_ready",  in_ready,  1'b0);
    check_eq("rst_out_valid", out_valid, 6'h00);
    check_eq("rst_out_data",  out_data,  102'h0);
`ifdef FANOUT_STALL_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    RESET = 1'b0;
    settle();
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Basic broadcast
    in_valid = 1'b1; in_data = 17'h00AB;
    tick();
    in_valid = 1'b0;
    settle();
    check_eq("basic_valid", out_valid, 6'h3F);
    check_eq("basic_data",  out_data,  {6{17'h00AB}});
    check_eq("basic_ready", in_ready,  1'b1);
    tick(); settle();
    check_eq("basic_retired", out_valid, 6'h00);

    // Staggered accept, mask 6'h07
    branch_sel = 6'h07; out_ready = 6'h00;
    in_valid = 1'b1; in_data = 17'h0111;
    tick();
    in_valid = 1'b0; out_ready = 6'h01; settle();
    check_eq("stag_c1_valid", out_valid, 6'h07);
    check_eq("stag_c1_data",  out_data,  {6{17'h0111}});
    tick(); out_ready = 6'h00; settle();
    check_eq("stag_c2_valid", out_valid, 6'h06);
    tick(); out_ready = 6'h02; settle();
    check_eq("stag_c3_valid", out_valid, 6'h06);
    tick(); out_ready = 6'h00; settle();
    check_eq("stag_c4_valid", out_valid, 6'h04);
    tick(); out_ready = 6'h3F; settle();
    check_eq("stag_c5_valid", out_valid, 6'h04);
    tick(); settle();
    check_eq("stag_c6_valid", out_valid, 6'h00);

    // Backpressure: three tokens against a stalled fabric
    branch_sel = 6'h3F; out_ready = 6'h00;
    in_valid = 1'b1; in_data = 17'h00001; settle();
    check_eq("bp_t1_ready", in_ready, 1'b1);
    tick(); in_data = 17'h00002; settle();
    check_eq("bp_t2_ready", in_ready, 1'b1);
    tick(); in_data = 17'h00003; settle();
    check_eq("bp_full_ready", in_ready,  1'b0);
    check_eq("bp_head1_data", out_data,  {6{17'h00001}});
    check_eq("bp_head1_valid", out_valid, 6'h3F);
    tick(); out_ready = 6'h3F; settle();
    check_eq("bp_bubble_ready", in_ready, 1'b0);
    check_eq("bp_head1_still",  out_data, {6{17'h00001}});
    tick(); settle();
    check_eq("bp_head2_data",  out_data,  {6{17'h00002}});
    check_eq("bp_head2_valid", out_valid, 6'h3F);
    check_eq("bp_t3_ready",    in_ready,  1'b1);
    tick(); in_valid = 1'b0; settle();
    check_eq("bp_head3_data",  out_data,  {6{17'h00003}});
    check_eq("bp_head3_valid", out_valid, 6'h3F);
    tick(); settle();
    check_eq("bp_drained", out_valid, 6'h00);

    // Zero mask: token dropped, follower unaffected
    branch_sel = 6'h00;
    in_valid = 1'b1; in_data = 17'h0055;
    tick();
    branch_sel = 6'h3F; in_data = 17'h0066; settle();
    check_eq("zm_no_valid", out_valid, 6'h00);
    check_eq("zm_ready",    in_ready,  1'b1);
    tick(); in_valid = 1'b0; settle();
    check_eq("zm_next_valid", out_valid, 6'h3F);
    check_eq("zm_next_data",  out_data,  {6{17'h0066}});
    tick(); settle();
    check_eq("zm_drained", out_valid, 6'h00);

    // Config change in flight
    branch_sel = 6'h03; out_ready = 6'h00;
    in_valid = 1'b1; in_data = 17'h0077;
    tick();
    branch_sel = 6'h30; in_data = 17'h0088; settle();
    check_eq("cfg_t1_valid", out_valid, 6'h03);
    tick(); in_valid = 1'b0; out_ready = 6'h3F; settle();
    check_eq("cfg_t1_valid_held", out_valid, 6'h03);
    check_eq("cfg_t1_data",       out_data,  {6{17'h0077}});
    tick(); settle();
    check_eq("cfg_t2_valid", out_valid, 6'h30);
    check_eq("cfg_t2_data",  out_data,  {6{17'h0088}});
    tick(); settle();
    check_eq("cfg_drained", out_valid, 6'h00);

    // Reset mid-token
    branch_sel = 6'h03; out_ready = 6'h00;
    in_valid = 1'b1; in_data = 17'h0099;
    tick();
    in_valid = 1'b0; out_ready = 6'h01; settle();
    check_eq("mid_valid_before", out_valid, 6'h03);
    tick(); out_ready = 6'h00; settle();
    check_eq("mid_valid_partial", out_valid, 6'h02);
    RESET = 1'b1; settle();
    check_eq("mid_rst_ready", in_ready, 1'b0);
    tick(); RESET = 1'b0; out_ready = 6'h3F; settle();
    check_eq("mid_after_valid", out_valid, 6'h00);
    check_eq("mid_after_data",  out_data,  102'h0);
    check_eq("mid_after_ready", in_ready,  1'b1);
`ifdef FANOUT_STALL_CNT_EN
    check_eq("mid_stall_cnt", stall_cnt, 32'h0);
`endif
    tick(); settle();
    check_eq("mid_never_redeliver", out_valid, 6'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
